// File: rtl/image_sequence_ctrl_if.sv
// -----------------------------------------------------------------------------
// image_sequence_ctrl_if
// Handshake bundle between the frame sequencer, the config store (delay fetch)
// and the A-line transmit engine.
//   dly_rd_req / dly_aline / dly_rd_ack : delay fetch request and one-cycle ack
//   tx_start / tx_ch_mask / tx_done     : A-line launch pulse, channel mask, done pulse
//   mem_clear                           : receive memory drained
// Modports: master = sequencer side, slave = config store / engine side.
// -----------------------------------------------------------------------------
interface image_sequence_ctrl_if #(
    parameter int NUM_CH  = 8,
    parameter int ALINE_W = 5
);
    logic               dly_rd_req;
    logic [ALINE_W-1:0] dly_aline;
    logic               dly_rd_ack;
    logic               tx_start;
    logic [NUM_CH-1:0]  tx_ch_mask;
    logic               tx_done;
    logic               mem_clear;

    modport master (
        output dly_rd_req, dly_aline, tx_start, tx_ch_mask,
        input  dly_rd_ack, tx_done, mem_clear
    );

    modport slave (
        input  dly_rd_req, dly_aline, tx_start, tx_ch_mask,
        output dly_rd_ack, tx_done, mem_clear
    );
endinterface

// File: rtl/image_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// image_sequence_ctrl
// Frame sequencer: fires the latched number of A-lines per image. For every
// A-line it fetches delays (req/ack), pulses tx_start, waits tx_done, then waits
// for receive-memory clear and the PRF holdoff before the next A-line.
// Abort drains the in-flight A-line; a saturating timeout guards every wait.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_start                 frame request (sampled in IDLE only)
//   i_abort                 stop frame after in-flight A-line drains
//   i_cfg_busy              config store updating, blocks start
//   i_num_alines            A-lines per frame (0 = start ignored)
//   i_prf_holdoff           minimum cycles between consecutive tx_start
//   i_ch_mask_in            enabled channels, latched at frame start
//   bus (master)            delay fetch + engine handshake
//   o_busy                  high in every state except IDLE
//   o_transmit_in_progress  high from first LOAD to frame end
//   o_aline_idx             current A-line index
//   o_frame_done            one-cycle pulse on normal frame completion
//   o_timeout_err           sticky, cleared by next accepted start
//
// Build option
//   IMAGE_SEQ_CONTINUOUS_EN : when defined, frames repeat back to back
//   (index wraps to 0 through WAIT_CLR) until abort or timeout.
// -----------------------------------------------------------------------------
module image_sequence_ctrl #(
    parameter int NUM_CH    = 8,
    parameter int ALINE_W   = 5,
    parameter int PRF_W     = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_cfg_busy,
    input  logic [ALINE_W-1:0]   i_num_alines,
    input  logic [PRF_W-1:0]     i_prf_holdoff,
    input  logic [NUM_CH-1:0]    i_ch_mask_in,
    image_sequence_ctrl_if.master bus,
    output logic                 o_busy,
    output logic                 o_transmit_in_progress,
    output logic [ALINE_W-1:0]   o_aline_idx,
    output logic                 o_frame_done,
    output logic                 o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_FIRE     = 3'd2,
        S_WAIT_TX  = 3'd3,
        S_WAIT_CLR = 3'd4,
        S_DRAIN    = 3'd5
    } state_t;

    localparam logic [ALINE_W-1:0]   A_ZERO   = {ALINE_W{1'b0}};
    localparam logic [ALINE_W-1:0]   A_ONE    = {{(ALINE_W-1){1'b0}}, 1'b1};
    localparam logic [PRF_W-1:0]     P_ZERO   = {PRF_W{1'b0}};
    localparam logic [PRF_W-1:0]     P_ONE    = {{(PRF_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] T_ZERO   = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] T_ONE    = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] T_MAX    = {TIMEOUT_W{1'b1}};
    localparam logic [NUM_CH-1:0]    M_ZERO   = {NUM_CH{1'b0}};

    state_t               r_state;
    logic [ALINE_W-1:0]   r_num;
    logic [PRF_W-1:0]     r_prf_hold;
    logic [NUM_CH-1:0]    r_mask;
    logic [ALINE_W-1:0]   r_aline_idx;
    logic [PRF_W-1:0]     r_prf_cnt;
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic                 r_clr_seen;
    logic                 r_dly_rd_req;
    logic [ALINE_W-1:0]   r_dly_aline;
    logic                 r_tx_start;
    logic                 r_busy;
    logic                 r_tip;
    logic                 r_frame_done;
    logic                 r_timeout_err;

    logic                 w_start_ok;
    logic                 w_last_aline;
    logic                 w_tmo_sat;
    logic                 w_prf_zero;
    logic                 w_clr_ok;
    logic [ALINE_W-1:0]   w_next_idx;

    assign w_start_ok   = i_start & ~i_cfg_busy & ~i_abort & (i_num_alines != A_ZERO);
    // Terminal compare against the latched count, so the index never wraps mid-frame.
    assign w_last_aline = (r_aline_idx == (r_num - A_ONE));
    assign w_tmo_sat    = (r_tmo_cnt == T_MAX);
    assign w_prf_zero   = (r_prf_cnt == P_ZERO);
    // A mem_clear pulse that arrived while the PRF holdoff was still running counts.
    assign w_clr_ok     = bus.mem_clear | r_clr_seen;
`ifdef IMAGE_SEQ_CONTINUOUS_EN
    assign w_next_idx   = w_last_aline ? A_ZERO : (r_aline_idx + A_ONE);
`else
    assign w_next_idx   = r_aline_idx + A_ONE;
`endif

    assign bus.dly_rd_req         = r_dly_rd_req;
    assign bus.dly_aline          = r_dly_aline;
    assign bus.tx_start           = r_tx_start;
    assign bus.tx_ch_mask         = r_mask;
    assign o_busy                 = r_busy;
    assign o_transmit_in_progress = r_tip;
    assign o_aline_idx            = r_aline_idx;
    assign o_frame_done           = r_frame_done;
    assign o_timeout_err          = r_timeout_err;

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_num         <= A_ZERO;
            r_prf_hold    <= P_ZERO;
            r_mask        <= M_ZERO;
            r_aline_idx   <= A_ZERO;
            r_prf_cnt     <= P_ZERO;
            r_tmo_cnt     <= T_ZERO;
            r_clr_seen    <= 1'b0;
            r_dly_rd_req  <= 1'b0;
            r_dly_aline   <= A_ZERO;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_tip         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            // PRF holdoff runs down in every active state; FIRE reloads it below.
            if ((r_state != S_IDLE) && !w_prf_zero) begin
                r_prf_cnt <= r_prf_cnt - P_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    r_prf_cnt    <= P_ZERO;
                    r_tmo_cnt    <= T_ZERO;
                    r_dly_rd_req <= 1'b0;
                    r_tip        <= 1'b0;
                    r_busy       <= 1'b0;
                    if (w_start_ok) begin
                        r_num         <= i_num_alines;
                        r_prf_hold    <= i_prf_holdoff;
                        r_mask        <= i_ch_mask_in;
                        r_aline_idx   <= A_ZERO;
                        r_dly_aline   <= A_ZERO;
                        r_timeout_err <= 1'b0;
                        r_clr_seen    <= 1'b0;
                        r_dly_rd_req  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_tip         <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (i_abort) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_tip        <= 1'b0;
                        r_dly_rd_req <= 1'b0;
                    end else if (bus.dly_rd_ack) begin
                        r_dly_rd_req <= 1'b0;
                        r_tx_start   <= 1'b1;
                        r_state      <= S_FIRE;
                    end else if (w_tmo_sat) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_tip         <= 1'b0;
                        r_dly_rd_req  <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + T_ONE;
                    end
                end

                S_FIRE: begin
                    r_prf_cnt <= r_prf_hold;
                    r_tmo_cnt <= T_ZERO;
                    r_state   <= i_abort ? S_DRAIN : S_WAIT_TX;
                end

                S_WAIT_TX: begin
                    if (bus.tx_done) begin
                        r_tmo_cnt <= T_ZERO;
                        if (i_abort) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_tip   <= 1'b0;
                        end else if (w_last_aline) begin
                            r_frame_done <= 1'b1;
`ifdef IMAGE_SEQ_CONTINUOUS_EN
                            r_state      <= S_WAIT_CLR;
`else
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_tip        <= 1'b0;
`endif
                        end else begin
                            r_state <= S_WAIT_CLR;
                        end
                    end else if (i_abort) begin
                        r_tmo_cnt <= r_tmo_cnt + T_ONE;
                        r_state   <= S_DRAIN;
                    end else if (w_tmo_sat) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_tip         <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + T_ONE;
                    end
                end

                S_WAIT_CLR: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tip   <= 1'b0;
                    end else if (w_clr_ok && w_prf_zero) begin
                        r_aline_idx  <= w_next_idx;
                        r_dly_aline  <= w_next_idx;
                        r_dly_rd_req <= 1'b1;
                        r_clr_seen   <= 1'b0;
                        r_tmo_cnt    <= T_ZERO;
                        r_state      <= S_LOAD;
                    end else if (w_tmo_sat) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_tip         <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + T_ONE;
                        if (bus.mem_clear) begin
                            r_clr_seen <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (bus.tx_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tip   <= 1'b0;
                    end else if (w_tmo_sat) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_tip         <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + T_ONE;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_tip        <= 1'b0;
                    r_dly_rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_image_sequence_ctrl
// Self-checking bench for image_sequence_ctrl. A responder plays the config
// store and transmit engine; a monitor records every tx_start. Each frame is
// compared against the expected outcome: N launches carrying indices 0..N-1,
// the start-time channel mask, PRF spacing, one frame_done, and an idle finish.
// -----------------------------------------------------------------------------
module tb_image_sequence_ctrl;
    localparam int NUM_CH = 8, ALINE_W = 5, PRF_W = 16, TIMEOUT_W = 6;

    logic clk = 1'b0;
    logic rst_n, start, abort, cfg_busy;
    logic [ALINE_W-1:0] num_alines;
    logic [PRF_W-1:0]   prf_holdoff;
    logic [NUM_CH-1:0]  ch_mask_in;
    logic busy, tip, frame_done, timeout_err;
    logic [ALINE_W-1:0] aline_idx;

    image_sequence_ctrl_if #(.NUM_CH(NUM_CH), .ALINE_W(ALINE_W)) bus ();

    image_sequence_ctrl #(.NUM_CH(NUM_CH), .ALINE_W(ALINE_W), .PRF_W(PRF_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_cfg_busy(cfg_busy),
        .i_num_alines(num_alines), .i_prf_holdoff(prf_holdoff), .i_ch_mask_in(ch_mask_in),
        .bus(bus), .o_busy(busy), .o_transmit_in_progress(tip), .o_aline_idx(aline_idx),
        .o_frame_done(frame_done), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // responder knobs
    int ack_dly = 2, done_dly = 20, clr_mode = 0, clr_dly = 1;
    // monitor observations
    int cyc = 0, ts_cnt = 0, fd_cnt = 0, last_start_cyc = -1, exp_prf = 0;
    int last_done_cyc = 0, busy_fall_cyc = 0;
    logic prev_start = 1'b0, prev_busy = 1'b0;
    logic [ALINE_W-1:0] aline_q[$];
    logic [NUM_CH-1:0]  mask_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Config store and engine stand-in, driven just after each rising edge.
    initial begin : responder
        int ack_wait, done_wait, clr_wait;
        ack_wait = -1; done_wait = -1; clr_wait = -1;
        bus.dly_rd_ack = 1'b0; bus.tx_done = 1'b0; bus.mem_clear = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.dly_rd_ack = 1'b0;
            bus.tx_done    = 1'b0;
            bus.mem_clear  = (clr_mode == 0);
            if (!rst_n) begin
                ack_wait = -1; done_wait = -1; clr_wait = -1;
            end else begin
                if (ack_wait == -1 && bus.dly_rd_req) ack_wait = ack_dly;
                else if (ack_wait >= 0 && !bus.dly_rd_req) ack_wait = -1;
                if (ack_wait == 0) begin bus.dly_rd_ack = 1'b1; ack_wait = -1; end
                else if (ack_wait > 0) ack_wait--;
                if (clr_wait == 0) begin bus.mem_clear = 1'b1; clr_wait = -1; end
                else if (clr_wait > 0) clr_wait--;
                if (bus.tx_start) done_wait = done_dly;
                if (done_wait == 0) begin
                    bus.tx_done = 1'b1; done_wait = -1;
                    if (clr_mode == 2) clr_wait = clr_dly;
                end else if (done_wait > 0) done_wait--;
            end
        end
    end

    // Observation of launches, frame ends and busy falls on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tx_done) last_done_cyc = cyc;
            if (frame_done) fd_cnt++;
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            if (bus.tx_start) begin
                check("tx_start_width", 32'(prev_start), 32'd0);
                if (last_start_cyc >= 0)
                    check("prf_spacing", 32'((cyc - last_start_cyc) >= exp_prf), 32'd1);
                last_start_cyc = cyc;
                ts_cnt++;
                aline_q.push_back(bus.dly_aline);
                mask_q.push_back(bus.tx_ch_mask);
            end
            prev_start = bus.tx_start;
            prev_busy  = busy;
        end
    end

    task automatic clear_obs();
        ts_cnt = 0; fd_cnt = 0; last_start_cyc = -1;
        aline_q.delete(); mask_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (busy !== 1'b0 && n < budget);
        check("wait_idle_bound", 32'(busy), 32'd0);
        @(negedge clk); #1;
    endtask

    task automatic wait_ts(input int target, input int budget);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (ts_cnt < target && n < budget);
        check("wait_tx_start_bound", 32'(ts_cnt >= target), 32'd1);
    endtask

    task automatic check_launches(input int n, input int modulo, input logic [NUM_CH-1:0] m);
        check("launch_count", 32'(ts_cnt), 32'(n));
        for (int i = 0; i < n && i < aline_q.size(); i++) begin
            check("dly_aline_seq", 32'(aline_q[i]), 32'(i % modulo));
            check("tx_ch_mask", 32'(mask_q[i]), 32'(m));
        end
    endtask

    // One complete single-shot frame with the latched inputs scrambled mid-frame.
    task automatic run_frame(input int n, input int p, input logic [NUM_CH-1:0] m);
        clear_obs();
        exp_prf = p; num_alines = ALINE_W'(n); prf_holdoff = PRF_W'(p); ch_mask_in = m;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        num_alines = ALINE_W'($urandom); prf_holdoff = PRF_W'($urandom_range(0, 3));
        ch_mask_in = NUM_CH'($urandom);
        wait_idle(4000);
        check_launches(n, n, m);
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("tip_after_frame", 32'(tip), 32'd0);
        check("timeout_err_clean", 32'(timeout_err), 32'd0);
    endtask

    initial begin : stimulus
        logic [NUM_CH-1:0] m;
        int diff;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_busy = 1'b0;
        num_alines = '0; prf_holdoff = '0; ch_mask_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tip", 32'(tip), 32'd0);
        check("rst_aline_idx", 32'(aline_idx), 32'd0);
        check("rst_req", 32'(bus.dly_rd_req), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_flags", 32'({frame_done, timeout_err}), 32'd0);
        check("rst_mask", 32'(bus.tx_ch_mask), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Start blocked by cfg_busy, by a zero count, and by a simultaneous abort.
        num_alines = 5'd3; cfg_busy = 1'b1;
        pulse_start(); @(posedge clk); #1;
        check("cfg_busy_blocks", 32'({busy, bus.dly_rd_req}), 32'd0);
        cfg_busy = 1'b0; num_alines = 5'd0;
        pulse_start(); @(posedge clk); #1;
        check("zero_alines_blocks", 32'(busy), 32'd0);
        num_alines = 5'd3; abort = 1'b1;
        pulse_start(); abort = 1'b0; @(posedge clk); #1;
        check("abort_beats_start", 32'(busy), 32'd0);

`ifndef IMAGE_SEQ_CONTINUOUS_EN
        // Directed frame: 3 A-lines, PRF 10, ack after 2, done after 20.
        ack_dly = 2; done_dly = 20; clr_mode = 0;
        run_frame(3, 10, 8'hA5);

        // Randomised frames, including late single-pulse mem_clear.
        for (int k = 0; k < 6; k++) begin
            ack_dly  = $urandom_range(0, 3);
            done_dly = $urandom_range(1, 25);
            clr_mode = (k % 2 == 0) ? 0 : 2;
            clr_dly  = $urandom_range(1, 30);
            run_frame($urandom_range(1, 6), $urandom_range(0, 30), NUM_CH'($urandom));
        end
`endif

        // Abort while waiting for tx_done of A-line 1.
        ack_dly = 2; done_dly = 20; clr_mode = 0;
        clear_obs(); exp_prf = 10;
        num_alines = 5'd4; prf_holdoff = 16'd10; ch_mask_in = 8'h3C;
        pulse_start();
        wait_ts(2, 500);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(posedge clk); #1;
        check("abort_drain_busy", 32'(busy), 32'd1);
        wait_idle(500);
        repeat (40) @(posedge clk);
        #1;
        check_launches(2, 4, 8'h3C);
        check("abort_no_frame_done", 32'(fd_cnt), 32'd0);
        check("abort_no_timeout", 32'(timeout_err), 32'd0);

        // mem_clear never arrives: saturating timeout after ~2^6 cycles in WAIT_CLR.
        clr_mode = 1; clear_obs(); exp_prf = 5;
        num_alines = 5'd2; prf_holdoff = 16'd5;
        pulse_start();
        wait_idle(600);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        check("timeout_one_launch", 32'(ts_cnt), 32'd1);
        check("timeout_no_frame_done", 32'(fd_cnt), 32'd0);
        diff = busy_fall_cyc - last_done_cyc;
        check("timeout_latency", 32'(diff >= 63 && diff <= 66), 32'd1);
        clr_mode = 0; clear_obs(); num_alines = 5'd1;
        pulse_start();
        check("timeout_err_cleared", 32'(timeout_err), 32'd0);
`ifdef IMAGE_SEQ_CONTINUOUS_EN
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle(500);
`else
        wait_idle(500);
        check("post_timeout_frame", 32'(fd_cnt), 32'd1);
`endif

        // Asynchronous reset while the engine is busy with A-line 0.
        clear_obs(); exp_prf = 10;
        num_alines = 5'd3; prf_holdoff = 16'd10; ch_mask_in = 8'h81;
        pulse_start();
        wait_ts(1, 200);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'({busy, tip, bus.dly_rd_req}), 32'd0);
        check("async_rst_idx", 32'(aline_idx), 32'd0);
        check("async_rst_mask", 32'(bus.tx_ch_mask), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
`ifndef IMAGE_SEQ_CONTINUOUS_EN
        run_frame(3, 10, 8'h81);
`else
        // Continuous: 2 A-lines per frame, index wraps, frame_done every frame.
        begin
            int n = 0;
            clear_obs(); exp_prf = 5; done_dly = 15;
            num_alines = 5'd2; prf_holdoff = 16'd5; ch_mask_in = 8'h0F;
            pulse_start();
            do begin @(posedge clk); #2; n++; end while (fd_cnt < 3 && n < 2000);
            check("cont_three_frames", 32'(fd_cnt), 32'd3);
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            wait_idle(500);
            check_launches(6, 2, 8'h0F);
            check("cont_no_timeout", 32'(timeout_err), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
